iomem_buttons: RTL and testbench
================================

Name: iomem_buttons

Overview:
Memory-mapped button peripheral on the picosoc iomem bus, alongside the GPIO register bank at 0x03xx_xxxx; the SoC-top address decode routes 0x04xx_xxxx here. Synchronises and debounces the raw board buttons, latches press events, and raises a level interrupt intended for picosoc irq_5. Gives firmware clean button state and events instead of raw pins.

Parameters:
NUM_BTN, 4, number of button inputs (1..8)
DEBOUNCE_CYCLES, 120000, consecutive stable clk cycles required to accept a new level (>=2); 10 ms at 12 MHz
ACTIVE_LOW, 1, 1 = pin low means pressed
BASE_HI, 8'h04, required value of iomem_addr[31:24] for selection

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
buttons  in  NUM_BTN  raw asynchronous button pins
iomem_valid  in  1  bus request
iomem_ready  out  1  one-cycle completion pulse
iomem_wstrb  in  4  byte write strobes; all zero = read
iomem_addr  in  32  byte address
iomem_wdata  in  32  write data
iomem_rdata  out  32  read data, valid while iomem_ready=1
btn_pressed  out  NUM_BTN  debounced pressed state, 1 = pressed
irq  out  1  registered level interrupt

Behaviour:
- Reset (async, resetn=0): synchroniser flops at the idle pin level (1 if ACTIVE_LOW, else 0); btn_pressed=0; all debounce counters=0; EVENT=0; IRQ_EN=0; iomem_ready=0; iomem_rdata=0; irq=0. Release is sampled on the next clk edge.
- Sync: 2-flop synchroniser per pin, then polarity correction to give sync_pressed. Pin-to-sync_pressed latency is 2 cycles.
- Debounce, per button:
  - Counter width is clog2(DEBOUNCE_CYCLES).
  - If sync_pressed == btn_pressed, counter is cleared.
  - Otherwise the counter increments. On the cycle it equals DEBOUNCE_CYCLES-1, btn_pressed toggles and the counter clears.
  - Any bounce back to the old level before acceptance restarts the count. Counters never wrap.
  - Total pin-to-btn_pressed latency is 2+DEBOUNCE_CYCLES cycles for a clean edge.
- Event: a btn_pressed 0->1 transition sets EVENT[i]. Release sets nothing.
- Registers (offset = iomem_addr[3:0], word aligned; bits above NUM_BTN read 0):
  - 0x0 STATE: ro, btn_pressed.
  - 0x4 EVENT: read; write-1-to-clear using wdata[NUM_BTN-1:0] when wstrb[0].
  - 0x8 IRQ_EN: rw, written when wstrb[0].
  - 0xC and above: read 0, writes ignored.
  - Only wstrb[0] is significant.
- Handshake:
  - Selection: iomem_valid && !iomem_ready && iomem_addr[31:24]==BASE_HI.
  - When selected, the next edge sets iomem_ready=1 for exactly one cycle, loads iomem_rdata, and performs the write.
  - Read latency is 1 cycle. Back-to-back accesses complete at most every 2 cycles.
  - Unselected address: iomem_ready stays 0 and nothing changes. iomem_rdata holds between accesses.
- Simultaneous EVENT set and W1C of the same bit: set wins (bit stays 1). A W1C of bit j does not affect another bit k being set.
- Read of EVENT returns the pre-edge value; the W1C applies after the read.
- irq: registered (EVENT & IRQ_EN) != 0. It asserts 1 cycle after either term becomes nonzero and deasserts 1 cycle after the clearing write.
- Mid-debounce reset: the count is lost, no event is generated, and no ready is issued for an in-flight access.

Decomposition:
- Shared package iomem_buttons_pkg holds the register offsets (STATE 4'h0, EVENT 4'h4, IRQ_EN 4'h8) and the default BASE_HI.
- One sub-module, button_debounce: a single channel with 2-flop sync, polarity, counter and stable output, parameterised by DEBOUNCE_CYCLES and ACTIVE_LOW, with a rise-pulse output.
- The top instantiates NUM_BTN copies of button_debounce plus the register and bus logic.

Test Plan:
1. DEBOUNCE_CYCLES=16, ACTIVE_LOW=1: drive buttons[0] low and hold -> btn_pressed[0]=1 exactly 18 cycles later; EVENT read at 0x0400_0004 returns 0x1.
2. Toggle buttons[1] low/high every 5 cycles for 100 cycles, then hold high -> btn_pressed[1] never asserts and EVENT stays 0x0.
3. Write IRQ_EN=0x1 at 0x0400_0008, then press button 0 -> irq=1 one cycle after the EVENT bit sets; write 0x1 to EVENT -> irq=0 one cycle after the ready pulse; EVENT reads 0x0.
4. Press button 2 so its EVENT set lands on the same edge as a W1C of 0x4 -> EVENT[2] reads 1 afterwards.
5. Hold iomem_valid with addr 0x0300_0000 -> iomem_ready never asserts. Read 0x0400_000C -> ready after 1 cycle, rdata 0x0. Write 0xF to STATE -> no change.
6. Assert resetn=0 mid-debounce and mid-access -> irq, iomem_ready and btn_pressed all go 0 with no clk edge; no event after release until a full 16-cycle stable press.

Source files
------------

// File: rtl/iomem_buttons_pkg.sv
// Shared definitions for the iomem button peripheral.
//   - Register offsets (iomem_addr[3:0]) for STATE / EVENT / IRQ_EN
//   - Default address-decode byte (iomem_addr[31:24])
//   - Decoded bus request struct used by the top-level register logic
package iomem_buttons_pkg;

    localparam logic [3:0] REG_STATE  = 4'h0;
    localparam logic [3:0] REG_EVENT  = 4'h4;
    localparam logic [3:0] REG_IRQ_EN = 4'h8;

    localparam logic [7:0] BASE_HI_DEFAULT = 8'h04;

    // One decoded iomem access, built combinationally from the bus pins.
    typedef struct packed {
        logic       sel;   // access is addressed to us and not yet acknowledged
        logic       wr;    // wstrb[0]: only the low byte lane is significant
        logic [3:0] off;   // register offset
    } bus_req_t;

endpackage

// File: rtl/iomem_buttons_if.sv
// picosoc iomem bus bundle.
//   master: drives valid/wstrb/addr/wdata, receives ready/rdata
//   slave : receives valid/wstrb/addr/wdata, drives ready/rdata
// iomem_wstrb == 0 means read; iomem_rdata is only meaningful while
// iomem_ready is high.
interface iomem_buttons_if;

    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );

endinterface

// File: rtl/iomem_buttons_debounce.sv
// Single button channel: 2-flop synchroniser, polarity correction and a
// stable-level debouncer.
//   clk, resetn : clock, asynchronous active-low reset
//   pin_i       : raw asynchronous button pin
//   pressed_o   : debounced state, 1 = pressed
//   rise_o      : combinational, high in the cycle whose closing edge takes
//                 pressed_o from 0 to 1 (lines up with the pressed_o update)
// A new level is accepted after DEBOUNCE_CYCLES consecutive cycles in which
// the synchronised level differs from pressed_o; any return to the old level
// restarts the count. Clean-edge latency pin -> pressed_o is 2+DEBOUNCE_CYCLES.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic resetn,
    input  logic pin_i,
    output logic pressed_o,
    output logic rise_o
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    // Synchroniser resets to the level an idle (released) pin sits at, so
    // coming out of reset never looks like a press.
    localparam logic          IDLE_LVL = ACTIVE_LOW;

    logic          meta_q;
    logic          sync_q;
    logic          pressed_q, pressed_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic sync_pressed;
    logic differ;
    logic accept;

    assign sync_pressed = sync_q ^ ACTIVE_LOW;
    assign differ       = sync_pressed != pressed_q;
    assign accept       = differ && (cnt_q == CNT_LAST);

    always_comb begin
        pressed_d = pressed_q;
        cnt_d     = cnt_q;
        if (!differ || accept) begin
            cnt_d = '0;
        end else begin
            // cnt_q < CNT_LAST here, so this never wraps
            cnt_d = cnt_q + CW'(1);
        end
        if (accept) begin
            pressed_d = ~pressed_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_q    <= IDLE_LVL;
            sync_q    <= IDLE_LVL;
            pressed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            meta_q    <= pin_i;
            sync_q    <= meta_q;
            pressed_q <= pressed_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pressed_o = pressed_q;
    assign rise_o    = accept && !pressed_q;

endmodule

// File: rtl/iomem_buttons.sv
// Memory-mapped button peripheral on the picosoc iomem bus (0x04xx_xxxx).
//   clk, resetn : clock, asynchronous active-low reset
//   buttons     : raw button pins (NUM_BTN)
//   bus         : iomem slave port (valid/ready/wstrb/addr/wdata/rdata)
//   btn_pressed : debounced pressed state, 1 = pressed
//   irq         : registered level interrupt, |(EVENT & IRQ_EN)
// Registers (offset iomem_addr[3:0], bits above NUM_BTN read 0):
//   0x0 STATE  ro   debounced pressed state
//   0x4 EVENT  w1c  latched press events (wdata[NUM_BTN-1:0] when wstrb[0])
//   0x8 IRQ_EN rw   interrupt enable per button (written when wstrb[0])
//   0xC+       reads 0, writes ignored
// Each selected access completes with a one-cycle ready pulse on the next
// edge; rdata holds its value between accesses.
module iomem_buttons
    import iomem_buttons_pkg::*;
#(
    parameter int         NUM_BTN         = 4,
    parameter int         DEBOUNCE_CYCLES = 120000,
    parameter bit         ACTIVE_LOW      = 1'b1,
    parameter logic [7:0] BASE_HI         = BASE_HI_DEFAULT
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NUM_BTN-1:0]  buttons,
    iomem_buttons_if.slave      bus,
    output logic [NUM_BTN-1:0]  btn_pressed,
    output logic                irq
);

    logic [NUM_BTN-1:0] rise;

    logic [NUM_BTN-1:0] event_q, event_d;
    logic [NUM_BTN-1:0] irq_en_q, irq_en_d;
    logic               ready_q, ready_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               irq_q, irq_d;

    bus_req_t           req;
    logic [31:0]        rd_val;
    logic [NUM_BTN-1:0] w1c;

    // ---------------------------------------------------------------
    // Per-button channels
    // ---------------------------------------------------------------
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_db (
            .clk       (clk),
            .resetn    (resetn),
            .pin_i     (buttons[i]),
            .pressed_o (btn_pressed[i]),
            .rise_o    (rise[i])
        );
    end

    // ---------------------------------------------------------------
    // Bus decode. Masking with !ready_q keeps a still-held valid from
    // being taken twice, so accesses complete at most every 2 cycles.
    // ---------------------------------------------------------------
    always_comb begin
        req.sel = bus.iomem_valid && !ready_q && (bus.iomem_addr[31:24] == BASE_HI);
        req.wr  = bus.iomem_wstrb[0];
        req.off = bus.iomem_addr[3:0];
    end

    // Read mux uses pre-edge register values (EVENT read sees the bits
    // before any W1C in the same access).
    always_comb begin
        rd_val = '0;
        case (req.off)
            REG_STATE:  rd_val[NUM_BTN-1:0] = btn_pressed;
            REG_EVENT:  rd_val[NUM_BTN-1:0] = event_q;
            REG_IRQ_EN: rd_val[NUM_BTN-1:0] = irq_en_q;
            default:    rd_val = '0;
        endcase
    end

    always_comb begin
        w1c      = '0;
        irq_en_d = irq_en_q;
        if (req.sel && req.wr) begin
            if (req.off == REG_EVENT) begin
                w1c = bus.iomem_wdata[NUM_BTN-1:0];
            end
            if (req.off == REG_IRQ_EN) begin
                irq_en_d = bus.iomem_wdata[NUM_BTN-1:0];
            end
        end
        // Clear first, then OR in new presses: a press landing on the same
        // edge as its own W1C survives.
        event_d = (event_q & ~w1c) | rise;
        ready_d = req.sel;
        rdata_d = req.sel ? rd_val : rdata_q;
        irq_d   = |(event_q & irq_en_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            event_q  <= '0;
            irq_en_q <= '0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            event_q  <= event_d;
            irq_en_q <= irq_en_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
        end
    end

    assign bus.iomem_ready = ready_q;
    assign bus.iomem_rdata = rdata_q;
    assign irq             = irq_q;

    // Address bits between the decode byte and the offset, the upper byte
    // lanes and the unused data bits carry no meaning for this block.
    logic unused_bus;
    assign unused_bus = ^{bus.iomem_addr[23:4], bus.iomem_wstrb[3:1],
                          bus.iomem_wdata[31:NUM_BTN]};

endmodule

// File: tb/tb_iomem_buttons.sv
// Bench for iomem_buttons: behavioural model + rdata scoreboard, directed
// scenarios followed by a randomized phase.
module tb_iomem_buttons;

    localparam int NB = 4;
    localparam int DC = 16;

    logic          clk    = 1'b0;
    logic          resetn = 1'b1;
    logic [NB-1:0] buttons = '1;
    logic [NB-1:0] btn_pressed;
    logic          irq;

    iomem_buttons_if bif();

    iomem_buttons #(
        .NUM_BTN         (NB),
        .DEBOUNCE_CYCLES (DC),
        .ACTIVE_LOW      (1'b1),
        .BASE_HI         (8'h04)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .buttons     (buttons),
        .bus         (bif.slave),
        .btn_pressed (btn_pressed),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------
    // Reference model. Debounce rule: a button's accepted state flips once
    // the last DC synchronised samples taken since the previous flip all
    // disagree with it. Samples reach the debouncer two edges after the pin.
    // ---------------------------------------------------------------
    logic [NB-1:0] m_pipe1 = '0, m_pipe2 = '0;
    logic [NB-1:0] m_pressed = '0, m_ev = '0, m_en = '0;
    bit            m_ready = 0, m_irq = 0;
    logic [31:0]   m_rdata = '0;
    bit            hist[NB][$];
    logic [31:0]   exp_q[$];

    logic [NB-1:0] m_rise, m_w1c;
    logic [31:0]   m_rd;
    bit            m_sel, m_irq_n, all_diff;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_pipe1 = '0; m_pipe2 = '0; m_pressed = '0; m_ev = '0; m_en = '0;
            m_ready = 0; m_irq = 0; m_rdata = '0;
            for (int i = 0; i < NB; i++) hist[i].delete();
            exp_q.delete();
        end else begin
            m_sel = bif.iomem_valid && !m_ready && (bif.iomem_addr[31:24] == 8'h04);
            m_rd  = '0;
            case (bif.iomem_addr[3:0])
                4'h0: m_rd = 32'(m_pressed);
                4'h4: m_rd = 32'(m_ev);
                4'h8: m_rd = 32'(m_en);
                default: m_rd = '0;
            endcase
            m_irq_n = (m_ev & m_en) != 0;
            for (int i = 0; i < NB; i++) begin
                m_rise[i] = 1'b0;
                hist[i].push_back(m_pipe2[i]);
                if (hist[i].size() > DC) void'(hist[i].pop_front());
                if (hist[i].size() == DC) begin
                    all_diff = 1;
                    for (int j = 0; j < DC; j++)
                        if (hist[i][j] == m_pressed[i]) all_diff = 0;
                    if (all_diff) begin
                        m_rise[i]    = !m_pressed[i];
                        m_pressed[i] = !m_pressed[i];
                        hist[i].delete();
                    end
                end
            end
            m_w1c = '0;
            if (m_sel && bif.iomem_wstrb[0]) begin
                if (bif.iomem_addr[3:0] == 4'h4) m_w1c = bif.iomem_wdata[NB-1:0];
                if (bif.iomem_addr[3:0] == 4'h8) m_en  = bif.iomem_wdata[NB-1:0];
            end
            m_ev    = (m_ev & ~m_w1c) | m_rise;
            m_ready = m_sel;
            if (m_sel) begin
                m_rdata = m_rd;
                exp_q.push_back(m_rd);
            end
            m_irq   = m_irq_n;
            m_pipe2 = m_pipe1;
            m_pipe1 = ~buttons;
        end
    end

    // ---------------------------------------------------------------
    // Monitor: compares DUT against the model away from the active edge.
    // ---------------------------------------------------------------
    logic [31:0] exp_rd;
    always @(negedge clk) begin
        if (resetn) begin
            chk(btn_pressed == m_pressed, "btn_pressed", 32'(btn_pressed), 32'(m_pressed));
            chk(irq == m_irq, "irq", 32'(irq), 32'(m_irq));
            chk(bif.iomem_ready == m_ready, "ready", 32'(bif.iomem_ready), 32'(m_ready));
            if (bif.iomem_ready || m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errs++;
                    $display("FAIL rdata_noexp: got 0x%0h with no expected response at %0t",
                             bif.iomem_rdata, $time);
                end else begin
                    exp_rd = exp_q.pop_front();
                    chk(bif.iomem_rdata == exp_rd, "rdata", bif.iomem_rdata, exp_rd);
                end
            end else begin
                chk(bif.iomem_rdata == m_rdata, "rdata_hold", bif.iomem_rdata, m_rdata);
            end
        end
    end

    // Bus access; caller is at a negedge. Returns rdata seen with ready.
    task automatic bus(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd,
                       output logic [31:0] rd);
        bit got = 0;
        bif.iomem_valid = 1'b1;
        bif.iomem_addr  = a;
        bif.iomem_wstrb = ws;
        bif.iomem_wdata = wd;
        rd = 'x;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bif.iomem_ready) begin
                got = 1;
                rd  = bif.iomem_rdata;
                break;
            end
        end
        bif.iomem_valid = 1'b0;
        bif.iomem_wstrb = '0;
        if (!got) begin
            checks++; errs++;
            $display("FAIL bus_timeout: no ready for addr 0x%0h at %0t", a, $time);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    logic [31:0] rd;

    initial begin
        bif.iomem_valid = 1'b0;
        bif.iomem_wstrb = '0;
        bif.iomem_addr  = '0;
        bif.iomem_wdata = '0;

        // Reset state
        #1 resetn = 1'b0;
        #1;
        chk(bif.iomem_ready == 1'b0, "rst_ready", 32'(bif.iomem_ready), 0);
        chk(bif.iomem_rdata == 32'h0, "rst_rdata", bif.iomem_rdata, 0);
        chk(irq == 1'b0, "rst_irq", 32'(irq), 0);
        chk(btn_pressed == '0, "rst_pressed", 32'(btn_pressed), 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // 1: clean press, latency 2+DC
        buttons[0] = 1'b0;
        repeat (17) @(negedge clk);
        chk(btn_pressed[0] == 1'b0, "t1_pressed_early", 32'(btn_pressed[0]), 0);
        @(negedge clk);
        chk(btn_pressed[0] == 1'b1, "t1_pressed_18", 32'(btn_pressed[0]), 1);
        bus(32'h0400_0004, 4'h0, 32'h0, rd);
        chk(rd == 32'h1, "t1_event", rd, 32'h1);
        bus(32'h0400_0004, 4'h1, 32'h1, rd);

        // 2: bouncing button never accepted
        for (int c = 0; c < 20; c++) begin
            buttons[1] = ~buttons[1];
            repeat (5) @(negedge clk);
        end
        buttons[1] = 1'b1;
        repeat (20) @(negedge clk);
        chk(btn_pressed[1] == 1'b0, "t2_bounce_pressed", 32'(btn_pressed[1]), 0);
        bus(32'h0400_0004, 4'h0, 32'h0, rd);
        chk(rd == 32'h0, "t2_event", rd, 32'h0);

        // 3: irq set/clear timing
        bus(32'h0400_0008, 4'h1, 32'h1, rd);
        buttons[0] = 1'b1;
        repeat (20) @(negedge clk);
        buttons[0] = 1'b0;
        repeat (18) @(negedge clk);
        chk(btn_pressed[0] == 1'b1, "t3_pressed", 32'(btn_pressed[0]), 1);
        chk(irq == 1'b0, "t3_irq_same_cycle", 32'(irq), 0);
        @(negedge clk);
        chk(irq == 1'b1, "t3_irq_set", 32'(irq), 1);
        bus(32'h0400_0004, 4'h1, 32'h1, rd);
        chk(irq == 1'b1, "t3_irq_at_ready", 32'(irq), 1);
        @(negedge clk);
        chk(irq == 1'b0, "t3_irq_clear", 32'(irq), 0);
        bus(32'h0400_0004, 4'h0, 32'h0, rd);
        chk(rd == 32'h0, "t3_event_clear", rd, 32'h0);

        // 4: EVENT set on the same edge as its W1C
        buttons[2] = 1'b0;
        repeat (17) @(negedge clk);
        bus(32'h0400_0004, 4'h1, 32'h4, rd);
        bus(32'h0400_0004, 4'h0, 32'h0, rd);
        chk(rd == 32'h4, "t4_set_wins", rd, 32'h4);

        // 5: unselected address, empty offset, write to read-only STATE
        bif.iomem_valid = 1'b1;
        bif.iomem_addr  = 32'h0300_0000;
        bif.iomem_wstrb = 4'h0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk(bif.iomem_ready == 1'b0, "t5_unselected", 32'(bif.iomem_ready), 0);
        end
        bif.iomem_valid = 1'b0;
        @(negedge clk);
        bus(32'h0400_000C, 4'h0, 32'h0, rd);
        chk(rd == 32'h0, "t5_reg_c", rd, 32'h0);
        bus(32'h0400_0000, 4'hF, 32'hF, rd);
        bus(32'h0400_0000, 4'h0, 32'h0, rd);
        chk(rd == 32'h5, "t5_state_ro", rd, 32'h5);

        // Randomized phase: button activity and bus traffic in parallel
        fork
            begin
                repeat (60) begin
                    buttons = buttons ^ NB'($urandom_range(0, 15));
                    repeat ($urandom_range(1, 40)) @(negedge clk);
                end
            end
            begin
                repeat (150) begin
                    logic [3:0] off, ws;
                    off = {2'($urandom_range(0, 3)), 2'b00};
                    ws  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
                    bus(32'h0400_0000 | 32'(off), ws, $urandom, rd);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
        join

        // 6: reset mid-debounce and mid-access
        buttons = '1;
        repeat (20) @(negedge clk);
        bus(32'h0400_0008, 4'h1, 32'hF, rd);
        bus(32'h0400_0004, 4'h1, 32'hF, rd);
        buttons[0] = 1'b0;
        repeat (20) @(negedge clk);
        chk(irq == 1'b1, "t6_irq_before", 32'(irq), 1);
        buttons[3] = 1'b0;
        repeat (8) @(negedge clk);
        bif.iomem_valid = 1'b1;
        bif.iomem_addr  = 32'h0400_0000;
        bif.iomem_wstrb = 4'h0;
        #1 resetn = 1'b0;
        #1;
        chk(irq == 1'b0, "t6_rst_irq", 32'(irq), 0);
        chk(bif.iomem_ready == 1'b0, "t6_rst_ready", 32'(bif.iomem_ready), 0);
        chk(btn_pressed == '0, "t6_rst_pressed", 32'(btn_pressed), 0);
        bif.iomem_valid = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (17) @(negedge clk);
        chk(btn_pressed == '0, "t6_no_early_press", 32'(btn_pressed), 0);
        @(negedge clk);
        chk(btn_pressed == 4'b1001, "t6_full_press", 32'(btn_pressed), 32'h9);
        bus(32'h0400_0004, 4'h0, 32'h0, rd);
        chk(rd == 32'h9, "t6_event", rd, 32'h9);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
